// File: rtl/gbf_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : gbf_fill_ctrl_if
//  Brief    : Signal bundle between the off-chip loader stream, the GBF
//             port-A write side and the gbf_controller_new handshake.
//             With GBF_FILL_STALL_CNT_EN defined the bundle also carries the
//             stall counter.
//  Revision : 1.0  initial release
// ============================================================================
interface gbf_fill_ctrl_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              finish;
    logic              buf1_need_data;
    logic              buf2_need_data;
    logic              en1a;
    logic              we1a;
    logic              en2a;
    logic              we2a;
    logic [ADDR_W-1:0] addr1a;
    logic [ADDR_W-1:0] addr2a;
    logic [DATA_W-1:0] w_data1a;
    logic [DATA_W-1:0] w_data2a;
    logic              buf1_ready;
    logic              buf2_ready;
    logic              data_avail;
`ifdef GBF_FILL_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    // Fill controller side
    modport slave (
        input  in_valid, in_data, finish, buf1_need_data, buf2_need_data,
        output in_ready, en1a, we1a, en2a, we2a, addr1a, addr2a,
        output w_data1a, w_data2a, buf1_ready, buf2_ready, data_avail
`ifdef GBF_FILL_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    // Loader / consumer / memory side
    modport master (
        output in_valid, in_data, finish, buf1_need_data, buf2_need_data,
        input  in_ready, en1a, we1a, en2a, we2a, addr1a, addr2a,
        input  w_data1a, w_data2a, buf1_ready, buf2_ready, data_avail
`ifdef GBF_FILL_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/gbf_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gbf_fill_ctrl
//  Brief    : Port-A writer for one double-buffered GBF. Fills buffer 1 and
//             buffer 2 in strict ping-pong order from a valid/ready stream,
//             reports bufN_ready / data_avail and refills a buffer after a
//             rising edge of bufN_need_data.
//             Optional macro GBF_FILL_STALL_CNT_EN adds a saturating 32-bit
//             stall_cnt output (cycles in a fill state with in_valid low).
//  Revision : 1.0  initial release
// ============================================================================
module gbf_fill_ctrl #(
    parameter int GBF_DATA_BITWIDTH = 512,
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int GBF_DEPTH         = 32,
    parameter int FILL_LEN          = 32
) (
    input  logic             clk,
    input  logic             reset,
    gbf_fill_ctrl_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL1 = 2'd1;
    localparam logic [1:0] S_FILL2 = 2'd2;

    // Fill length can never exceed the buffer depth
    localparam int                           C_LEN  = (FILL_LEN > GBF_DEPTH) ? GBF_DEPTH : FILL_LEN;
    localparam logic [GBF_ADDR_BITWIDTH-1:0] C_LAST = GBF_ADDR_BITWIDTH'(C_LEN - 1);
    localparam logic [GBF_ADDR_BITWIDTH-1:0] C_ONE  = GBF_ADDR_BITWIDTH'(1);

    logic [1:0]                   r_state;
    logic [1:0]                   w_state_nxt;
    logic                         r_next_buf2;   // 0: buffer 1 is next, 1: buffer 2
    logic [GBF_ADDR_BITWIDTH-1:0] r_wcnt;
    logic                         r_full1;
    logic                         r_full2;
    logic                         r_done1;       // fill of buffer 1 just finished
    logic                         r_done2;
    logic                         r_need1_q;
    logic                         r_need2_q;
    logic                         r_data_avail;
    logic                         r_en1a;
    logic                         r_en2a;
    logic [GBF_ADDR_BITWIDTH-1:0] r_addr1a;
    logic [GBF_ADDR_BITWIDTH-1:0] r_addr2a;
    logic [GBF_DATA_BITWIDTH-1:0] r_wdata1a;
    logic [GBF_DATA_BITWIDTH-1:0] r_wdata2a;

    logic w_fill;
    logic w_beat;
    logic w_last;
    logic w_beat1;
    logic w_beat2;

    assign w_fill  = (r_state == S_FILL1) || (r_state == S_FILL2);
    assign w_beat  = w_fill && bus.in_valid;
    assign w_last  = w_beat && (r_wcnt == C_LAST);
    assign w_beat1 = w_beat && (r_state == S_FILL1);
    assign w_beat2 = w_beat && (r_state == S_FILL2);

    // Next-state decode; a pending done blocks re-entry before full is set
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!bus.finish) begin
                    if (!r_next_buf2 && !r_full1 && !r_done1)
                        w_state_nxt = S_FILL1;
                    else if (r_next_buf2 && !r_full2 && !r_done2)
                        w_state_nxt = S_FILL2;
                end
            end
            S_FILL1, S_FILL2: begin
                if (w_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, write counter and ping-pong pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_next_buf2 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_beat)
                r_wcnt <= w_last ? '0 : r_wcnt + C_ONE;
            if (w_last)
                r_next_buf2 <= ~r_next_buf2;
        end
    end

    // Full flags: set one cycle after the final write, cleared on drain edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done1      <= 1'b0;
            r_done2      <= 1'b0;
            r_full1      <= 1'b0;
            r_full2      <= 1'b0;
            r_need1_q    <= 1'b0;
            r_need2_q    <= 1'b0;
            r_data_avail <= 1'b0;
        end else begin
            r_done1   <= w_last && (r_state == S_FILL1);
            r_done2   <= w_last && (r_state == S_FILL2);
            r_need1_q <= bus.buf1_need_data;
            r_need2_q <= bus.buf2_need_data;
            if (r_done1)
                r_full1 <= 1'b1;
            else if (bus.buf1_need_data && !r_need1_q && r_full1)
                r_full1 <= 1'b0;
            if (r_done2)
                r_full2 <= 1'b1;
            else if (bus.buf2_need_data && !r_need2_q && r_full2)
                r_full2 <= 1'b0;
            if (r_done1 || r_done2)
                r_data_avail <= 1'b1;
        end
    end

    // Registered port-A write for each accepted beat; address/data hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en1a    <= 1'b0;
            r_en2a    <= 1'b0;
            r_addr1a  <= '0;
            r_addr2a  <= '0;
            r_wdata1a <= '0;
            r_wdata2a <= '0;
        end else begin
            r_en1a <= w_beat1;
            r_en2a <= w_beat2;
            if (w_beat1) begin
                r_addr1a  <= r_wcnt;
                r_wdata1a <= bus.in_data;
            end
            if (w_beat2) begin
                r_addr2a  <= r_wcnt;
                r_wdata2a <= bus.in_data;
            end
        end
    end

    assign bus.in_ready   = w_fill;
    assign bus.en1a       = r_en1a;
    assign bus.we1a       = r_en1a;
    assign bus.en2a       = r_en2a;
    assign bus.we2a       = r_en2a;
    assign bus.addr1a     = r_addr1a;
    assign bus.addr2a     = r_addr2a;
    assign bus.w_data1a   = r_wdata1a;
    assign bus.w_data2a   = r_wdata2a;
    assign bus.buf1_ready = r_full1;
    assign bus.buf2_ready = r_full2;
    assign bus.data_avail = r_data_avail;

`ifdef GBF_FILL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of fill cycles with no upstream word
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (w_fill && !bus.in_valid && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gbf_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gbf_fill_ctrl
//  Brief    : Directed self-checking bench for gbf_fill_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gbf_fill_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    gbf_fill_ctrl_if #(.DATA_W(512), .ADDR_W(5)) bus ();

    gbf_fill_ctrl #(
        .GBF_DATA_BITWIDTH (512),
        .GBF_ADDR_BITWIDTH (5),
        .GBF_DEPTH         (32),
        .FILL_LEN          (32)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mkw(input int v);
        logic [31:0] w;
        w   = 32'(v);
        mkw = {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted beat into buffer b; checks the registered write next cycle
    task automatic beat(input int b, input int v, input int a);
        bus.in_valid = 1'b1;
        bus.in_data  = mkw(v);
        chk("beat_in_ready", 512'(bus.in_ready), 512'(1));
        tick();
        bus.in_valid = 1'b0;
        if (b == 1) begin
            chk("wr1_en",   512'(bus.en1a & bus.we1a), 512'(1));
            chk("wr1_addr", 512'(bus.addr1a), 512'(a));
            chk("wr1_data", bus.w_data1a, mkw(v));
            chk("wr1_other_idle", 512'(bus.en2a | bus.we2a), 512'(0));
        end else begin
            chk("wr2_en",   512'(bus.en2a & bus.we2a), 512'(1));
            chk("wr2_addr", 512'(bus.addr2a), 512'(a));
            chk("wr2_data", bus.w_data2a, mkw(v));
            chk("wr2_other_idle", 512'(bus.en1a | bus.we1a), 512'(0));
        end
    endtask

    task automatic fill(input int b, input int base, input int first, input int last);
        for (int i = first; i <= last; i++)
            beat(b, base + i, i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 512'(bus.in_ready), 512'(0));
        chk({tag, "_en"}, 512'({bus.en1a, bus.we1a, bus.en2a, bus.we2a}), 512'(0));
        chk({tag, "_addr"}, 512'({bus.addr1a, bus.addr2a}), 512'(0));
        chk({tag, "_wdata1"}, bus.w_data1a, 512'(0));
        chk({tag, "_wdata2"}, bus.w_data2a, 512'(0));
        chk({tag, "_ready"}, 512'({bus.buf1_ready, bus.buf2_ready}), 512'(0));
        chk({tag, "_avail"}, 512'(bus.data_avail), 512'(0));
`ifdef GBF_FILL_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, 512'(bus.stall_cnt), 512'(0));
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset              = 1'b1;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.finish         = 1'b0;
        bus.buf1_need_data = 1'b0;
        bus.buf2_need_data = 1'b0;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        chk("idle_after_reset", 512'(bus.in_ready), 512'(0));
        tick();

        // Continuous fill of buffer 1 with words 0..31
        fill(1, 0, 0, 31);
        chk("b1_last_in_ready", 512'(bus.in_ready), 512'(0));
        chk("b1_ready_early", 512'(bus.buf1_ready), 512'(0));
        chk("avail_early", 512'(bus.data_avail), 512'(0));
        tick();
        chk("b1_ready_rise", 512'(bus.buf1_ready), 512'(1));
        chk("avail_rise", 512'(bus.data_avail), 512'(1));
        chk("fill2_start", 512'(bus.in_ready), 512'(1));
        chk("b2_not_ready", 512'(bus.buf2_ready), 512'(0));

        // Fill buffer 2
        fill(2, 100, 0, 31);
        chk("b2_last_in_ready", 512'(bus.in_ready), 512'(0));
        tick();
        chk("b2_ready_rise", 512'(bus.buf2_ready), 512'(1));
        chk("b1_still_ready", 512'(bus.buf1_ready), 512'(1));

        // Both full: nothing accepted
        bus.in_valid = 1'b1;
        bus.in_data  = mkw(999);
        for (int i = 0; i < 3; i++) begin
            chk("both_full_in_ready", 512'(bus.in_ready), 512'(0));
            tick();
            chk("both_full_no_wr", 512'(bus.en1a | bus.en2a), 512'(0));
        end
        bus.in_valid = 1'b0;

        // Drain buffer 1, refill it with a 5-cycle stall at wcnt=10
        bus.buf1_need_data = 1'b1;
        tick();
        chk("drain1_ready_fall", 512'(bus.buf1_ready), 512'(0));
        chk("drain1_b2_kept", 512'(bus.buf2_ready), 512'(1));
        chk("drain1_idle", 512'(bus.in_ready), 512'(0));
        bus.buf1_need_data = 1'b0;
        tick();
        chk("refill1_start", 512'(bus.in_ready), 512'(1));
        fill(1, 200, 0, 9);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_no_wr", 512'(bus.en1a | bus.en2a), 512'(0));
        end
`ifdef GBF_FILL_STALL_CNT_EN
        chk("stall_cnt", 512'(bus.stall_cnt), 512'(5));
`endif
        fill(1, 200, 10, 31);
        tick();
        chk("refill1_ready", 512'(bus.buf1_ready), 512'(1));

        // Drain buffer 2, reset mid-fill at wcnt=20
        bus.buf2_need_data = 1'b1;
        tick();
        chk("drain2_ready_fall", 512'(bus.buf2_ready), 512'(0));
        tick();
        chk("refill2_start", 512'(bus.in_ready), 512'(1));
        bus.buf2_need_data = 1'b0;
        fill(2, 300, 0, 19);
        reset = 1'b1;
        tick();
        chk_all_zero("midreset");
        reset = 1'b0;
        chk("midreset_idle", 512'(bus.in_ready), 512'(0));
        tick();
        chk("after_reset_fill1", 512'(bus.in_ready), 512'(1));
        beat(1, 400, 0);

        // finish during a buffer-1 fill: fill completes, nothing further
        bus.finish = 1'b1;
        fill(1, 400, 1, 31);
        tick();
        chk("finish_b1_ready", 512'(bus.buf1_ready), 512'(1));
        chk("finish_avail", 512'(bus.data_avail), 512'(1));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("finish_in_ready", 512'(bus.in_ready), 512'(0));
            tick();
            chk("finish_no_wr2", 512'(bus.en2a), 512'(0));
            chk("finish_b2_empty", 512'(bus.buf2_ready), 512'(0));
        end
        bus.in_valid = 1'b0;

        // buf2_need_data held high from reset: only a fresh edge drains
        bus.finish         = 1'b0;
        bus.buf2_need_data = 1'b1;
        reset              = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        fill(1, 500, 0, 31);
        tick();
        chk("hold_fill2_start", 512'(bus.in_ready), 512'(1));
        fill(2, 600, 0, 31);
        tick();
        chk("hold_b2_ready", 512'(bus.buf2_ready), 512'(1));
        tick();
        tick();
        chk("hold_no_drain", 512'(bus.buf2_ready), 512'(1));
        bus.buf2_need_data = 1'b0;
        tick();
        chk("hold_low_no_drain", 512'(bus.buf2_ready), 512'(1));
        bus.buf2_need_data = 1'b1;
        tick();
        chk("fresh_edge_drain", 512'(bus.buf2_ready), 512'(0));
        chk("fresh_edge_b1_kept", 512'(bus.buf1_ready), 512'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gbf_fill_ctrl.md
# gbf_fill_ctrl

Port-A writer for one double-buffered GBF (activation or weight). It accepts a valid/ready word stream from the off-chip loader and fills GBF buffer 1 and buffer 2 in strict ping-pong order. It raises `bufN_ready` and `data_avail` toward `gbf_controller_new` and refills a buffer once that controller signals `bufN_need_data`. It is the producer end of the `need_data`/`buf_ready` handshake; `gbf_controller_new` consumes through port B. One instance is used per operand.

## Interface
- GBF_DATA_BITWIDTH, 512, GBF word width
- GBF_ADDR_BITWIDTH, 5, port-A address width
- GBF_DEPTH, 32, words per buffer
- FILL_LEN, 32, words written per fill (1..GBF_DEPTH)
- Clock/reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  upstream word valid
- in_data  in  GBF_DATA_BITWIDTH  upstream word
- in_ready  out  1  word accepted when in_valid & in_ready
- finish  in  1  stop accepting new fills
- buf1_need_data, buf2_need_data  in  1  consumer has drained buffer N (level; rising edge is significant)
- en1a, we1a, en2a, we2a  out  1  port-A enable/write-enable per buffer
- addr1a, addr2a  out  GBF_ADDR_BITWIDTH  port-A address
- w_data1a, w_data2a  out  GBF_DATA_BITWIDTH  port-A write data
- buf1_ready, buf2_ready  out  1  buffer N full and valid
- data_avail  out  1  at least one fill completed since reset

## Operation
- State machine:
  - States: IDLE, FILL1, FILL2.
  - Register `next_buf` is reset to 1 and toggles after each completed fill.
  - Register `full1`/`full2` is reset to 0.
- IDLE transitions: go to FILLn when `!finish & next_buf==n & !fulln`; otherwise stay in IDLE.
- FILLn:
  - `in_ready`=1.
  - Each accepted beat writes `in_data` to buffer n at address `wcnt`, then `wcnt++`.
  - On the beat with `wcnt==FILL_LEN-1`: `wcnt`←0, set `fulln` (effective per Timing), toggle `next_buf`, go to IDLE.
- Drain detection: a rising edge of `bufN_need_data` (compared against a registered copy) while `fullN`=1 clears `fullN`. Edges seen while `fullN`=0 are ignored.
- Outputs:
  - `bufN_ready` = `fullN`.
  - `data_avail` sets on the first fill completion and stays high until reset.
- `finish` is sampled only in IDLE. A fill in progress always completes.
- Simultaneous events: a fill completing on one buffer and a drain of the other buffer in the same cycle both take effect.
- Reset mid-fill aborts the fill. All state and outputs are cleared, and the partial buffer is never reported ready.

## Timing
- Reset values:
  - 0: `in_ready`, all `en`/`we`, `addr*`, `w_data*`, `buf*_ready`, `data_avail`.
  - State IDLE, `next_buf`=1, `wcnt`=0.
- `in_ready` is a registered state decode: high from the first cycle in FILLn through the cycle of the last beat.
- IDLE→FILLn takes 1 cycle. Back-to-back fills have one IDLE cycle between them.
- Port-A outputs are registered:
  - A beat accepted in cycle t drives `enNa`=`weNa`=1, `addrNa`=wcnt and `w_dataNa`=data in cycle t+1.
  - Enables are 0 in all other cycles; the other buffer's port stays idle.
- Last beat accepted at t: final write at t+1; `bufN_ready` and `data_avail` rise at t+2.
- Drain: `bufN_need_data` rises at t; `bufN_ready` falls at t+1. A refill can then begin in IDLE at t+1 (FILLn at t+2).
- Stall: when `in_valid`=0 in FILLn, no write occurs and `wcnt` holds.

## Configuration
- `GBF_FILL_STALL_CNT_EN` defined:
  - Adds output `stall_cnt` (32 bits, reset 0).
  - It increments every cycle in FILL1/FILL2 with `in_valid`=0 and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then stream 32 words 0..31 continuously:
  - buffer 1 receives addresses 0..31 with matching data on consecutive cycles;
  - `buf1_ready`/`data_avail` rise 2 cycles after the last beat;
  - FILL2 starts 1 cycle after IDLE.
- Fill both buffers, pulse `buf1_need_data`:
  - `buf1_ready` falls next cycle;
  - the next 32 words go to buffer 1, never buffer 2;
  - `in_ready` stays 0 while both buffers are full.
- Deassert `in_valid` for 5 cycles mid-fill at `wcnt`=10:
  - no writes during the gap, writing resumes at address 10;
  - with the macro, `stall_cnt`=5.
- Assert reset at `wcnt`=20 of a buffer-2 fill:
  - all outputs are 0 next cycle;
  - the next fill targets buffer 1 at address 0.
- Assert `finish` during a fill of buffer 1: the fill completes and `buf1_ready` rises, then `in_ready` stays 0 even with buffer 2 empty.
- Hold `buf2_need_data` high from reset: no drain occurs until a fresh rising edge after `buf2_ready`=1.
